// File: rtl/edge_capture_pkg.sv
// edge_capture_pkg
//   Shared types and helpers for the binarised frame-capture block.
//   - cap_state_t : capture controller states
//   - frame_bytes : bytes needed to hold one bit-packed frame (8 px/byte)
package edge_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  function automatic int frame_bytes(input int h, input int v);
    return (h * v) / 8;
  endfunction

endpackage

// File: rtl/bit_frame_ram.sv
// bit_frame_ram
//   Simple dual-port 8 x DEPTH frame store. One synchronous write port and
//   one registered read port; no reset on the array or the read register so
//   the storage maps onto block RAM.
// Ports:
//   clk            clock
//   we/waddr/wdata write strobe, byte address, packed pixel byte
//   re/raddr       read strobe and byte address
//   rdata          read data, valid the cycle after re
module bit_frame_ram #(
  parameter int DEPTH = 3168,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Callers guarantee both addresses are below DEPTH when strobed.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/edge_frame_capture.sv
// edge_frame_capture
//   Thresholds a smoothed grayscale pixel stream to 1 bit/pixel and, on
//   request, captures exactly one complete frame into a bit-packed RAM
//   (bit 7 of each byte = leftmost pixel). The held frame is read back
//   through a 1-cycle-latency random-access port while idle or done.
// Ports:
//   clk, rstn            clock, async active-low reset
//   i_vsync              frame sync, rising edge = frame boundary
//   i_hsync              line sync (unused; pixels are counted by i_de)
//   i_de, i_data         pixel valid and pixel value
//   i_threshold          binarisation threshold, latched on i_capture
//   i_capture            capture request (accepted in IDLE/DONE)
//   o_busy               armed or capturing
//   o_done               a complete frame is held
//   o_err                1-cycle pulse when a frame was truncated by vsync
//   i_rd_en, i_rd_addr   read strobe and byte address
//   o_rd_data,o_rd_valid read result, 1 cycle after an accepted read
module edge_frame_capture
  import edge_capture_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int H_RES       = 176,
  parameter int V_RES       = 144,
  parameter int INVERT      = 0,
  parameter int FRAME_BYTES = frame_bytes(H_RES, V_RES),
  parameter int AW          = $clog2(FRAME_BYTES)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_vsync,
  input  logic             i_hsync,
  input  logic             i_de,
  input  logic [WIDTH-1:0] i_data,
  input  logic [WIDTH-1:0] i_threshold,
  input  logic             i_capture,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [7:0]       o_rd_data,
  output logic             o_rd_valid
);

  localparam logic INV = (INVERT != 0);

  cap_state_t       state, state_nxt;
  logic             vsync_q;
  logic             vs_rise;
  logic [WIDTH-1:0] thr_q;
  logic [2:0]       pix_cnt;
  logic [AW-1:0]    byte_addr;
  logic [6:0]       shreg;
  logic             err_q;
  logic             rd_valid_q;
  logic             rd_oor_q;
  logic [7:0]       ram_rdata;

  logic             idle_like;
  logic             pix_bit;
  logic             pix_take;
  logic             wr_en;
  logic             last_byte;
  logic             restart;
  logic             rd_acc;
  logic             rd_in_range;

  // Line sync carries no information here; pixels are counted by i_de.
  logic unused_hsync;
  assign unused_hsync = i_hsync;

  assign vs_rise   = i_vsync & ~vsync_q;
  assign idle_like = (state == IDLE) || (state == DONE);

  // Unsigned compare at WIDTH bits; equality counts as bright.
  assign pix_bit   = (i_data >= thr_q) ^ INV;

  // A vsync edge during capture restarts the frame and takes priority over
  // a pixel presented in the same cycle, which is dropped.
  assign restart   = vs_rise && ((state == ARMED) || (state == CAPTURE));
  assign pix_take  = (state == CAPTURE) && i_de && !vs_rise;
  assign wr_en     = pix_take && (pix_cnt == 3'd7);
  assign last_byte = (int'(byte_addr) == FRAME_BYTES - 1);

  assign rd_acc      = i_rd_en && idle_like;
  assign rd_in_range = (int'(i_rd_addr) < FRAME_BYTES);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (i_capture)           state_nxt = ARMED;
      ARMED:      if (vs_rise)             state_nxt = CAPTURE;
      CAPTURE:    if (wr_en && last_byte)  state_nxt = DONE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // ---------------- packer / counters ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vsync_q   <= 1'b0;
      thr_q     <= '0;
      pix_cnt   <= 3'd0;
      byte_addr <= '0;
      shreg     <= 7'd0;
      err_q     <= 1'b0;
    end else begin
      vsync_q <= i_vsync;
      err_q   <= (state == CAPTURE) && vs_rise;

      if (idle_like && i_capture) thr_q <= i_threshold;

      if (restart) begin
        pix_cnt   <= 3'd0;
        byte_addr <= '0;
      end else if (pix_take) begin
        shreg   <= {shreg[5:0], pix_bit};
        pix_cnt <= pix_cnt + 3'd1;
        if (wr_en) byte_addr <= byte_addr + AW'(1);
      end
    end
  end

  // ---------------- frame store ----------------
  bit_frame_ram #(
    .DEPTH (FRAME_BYTES),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (byte_addr),
    .wdata ({shreg, pix_bit}),
    .re    (rd_acc && rd_in_range),
    .raddr (i_rd_addr),
    .rdata (ram_rdata)
  );

  // ---------------- read port ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_valid_q <= 1'b0;
      rd_oor_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      rd_oor_q   <= rd_acc && !rd_in_range;
    end
  end

  // The RAM read register has no reset, so data is forced to zero whenever
  // no in-range read is being returned.
  assign o_rd_data  = (rd_valid_q && !rd_oor_q) ? ram_rdata : 8'h00;
  assign o_rd_valid = rd_valid_q;

  assign o_busy = (state == ARMED) || (state == CAPTURE);
  assign o_done = (state == DONE);
  assign o_err  = err_q;

endmodule

// File: tb/tb_edge_frame_capture.sv
// tb_edge_frame_capture
//   Two instances (INVERT=0 and INVERT=1) share one stimulus stream. Expected
//   frame bytes come from the list of pixels that belong to the completed
//   frame and the latched threshold, packed with plain arithmetic.
module tb_edge_frame_capture;
  localparam int H  = 16;
  localparam int V  = 3;
  localparam int FB = H * V / 8;   // 6
  localparam int AW = 3;
  localparam int NP = H * V;       // 48

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_vsync, i_hsync, i_de, i_capture, i_rd_en;
  logic [7:0]    i_data, i_threshold;
  logic [AW-1:0] i_rd_addr;
  logic          busy[2], done[2], err[2], rd_valid[2];
  logic [7:0]    rd_data[2];

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt[2];

  logic [7:0] pix_q[$];   // pixels of the frame expected to be stored
  logic [7:0] stim_q[$];  // pixels to drive next
  logic [7:0] thr_m;
  int         cap_at = -1;
  bit         noise  = 1'b0;

  always #5 clk = ~clk;

  edge_frame_capture #(.WIDTH(8), .H_RES(H), .V_RES(V), .INVERT(0)) u_dut (
    .clk(clk), .rstn(rstn), .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de),
    .i_data(i_data), .i_threshold(i_threshold), .i_capture(i_capture),
    .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0]), .i_rd_en(i_rd_en),
    .i_rd_addr(i_rd_addr), .o_rd_data(rd_data[0]), .o_rd_valid(rd_valid[0]));

  edge_frame_capture #(.WIDTH(8), .H_RES(H), .V_RES(V), .INVERT(1)) u_inv (
    .clk(clk), .rstn(rstn), .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de),
    .i_data(i_data), .i_threshold(i_threshold), .i_capture(i_capture),
    .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1]), .i_rd_en(i_rd_en),
    .i_rd_addr(i_rd_addr), .o_rd_data(rd_data[1]), .o_rd_valid(rd_valid[1]));

  always @(negedge clk) begin
    if (err[0]) err_cnt[0]++;
    if (err[1]) err_cnt[1]++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k, input bit inv);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[7-j] = (pix_q[8*k+j] >= thr_m) ^ inv;
    return b;
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  // One cycle of the stream; while noise is set, reads are attempted during
  // capture and must never be accepted.
  task automatic step();
    cyc();
    if (noise) begin
      chk("rd_valid_busy0", 32'(rd_valid[0]), 0);
      chk("rd_valid_busy1", 32'(rd_valid[1]), 0);
    end
  endtask

  task automatic arm(input logic [7:0] thr);
    i_capture = 1'b1; i_threshold = thr; thr_m = thr;
    cyc();
    i_capture = 1'b0; i_threshold = 8'($urandom);
    chk("busy_armed", 32'(busy[0]), 1);
    chk("done_armed", 32'(done[0]), 0);
  endtask

  task automatic vs_pulse();
    i_vsync = 1'b1; cyc();
    i_vsync = 1'b0; cyc();
  endtask

  task automatic stream(input int gap_max);
    foreach (stim_q[i]) begin
      repeat ($urandom_range(gap_max, 0)) begin
        i_de = 1'b0; i_data = 8'($urandom); i_hsync = 1'($urandom);
        i_rd_en = noise & 1'($urandom); i_rd_addr = 3'($urandom);
        step();
      end
      i_capture = (i == cap_at);
      if (i == cap_at) i_threshold = 8'h00;
      i_de = 1'b1; i_data = stim_q[i]; i_hsync = 1'($urandom);
      i_rd_en = noise & 1'($urandom); i_rd_addr = 3'($urandom);
      pix_q.push_back(stim_q[i]);
      step();
    end
    i_de = 1'b0; i_capture = 1'b0; i_rd_en = 1'b0;
    stim_q.delete();
  endtask

  task automatic rand_stim(input int n);
    for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
  endtask

  task automatic check_done(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_done"}, 32'(done[d]), 1);
      chk({tag, "_busy"}, 32'(busy[d]), 0);
    end
  endtask

  // Back-to-back reads of every address including two past the frame.
  task automatic read_all();
    for (int k = 0; k < 8; k++) begin
      i_rd_en = 1'b1; i_rd_addr = 3'(k);
      cyc();
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rd_valid[%0d]", k), 32'(rd_valid[d]), 1);
        chk($sformatf("rd_data%0d[%0d]", d, k), 32'(rd_data[d]),
            32'((k < FB) ? exp_byte(k, 1'(d)) : 8'h00));
      end
    end
    i_rd_en = 1'b0;
    cyc();
    chk("rd_valid_idle0", 32'(rd_valid[0]), 0);
    chk("rd_valid_idle1", 32'(rd_valid[1]), 0);
  endtask

  initial begin
    rstn = 1'b0; i_vsync = 0; i_hsync = 0; i_de = 0; i_capture = 0; i_rd_en = 0;
    i_data = 0; i_threshold = 0; i_rd_addr = 0;
    err_cnt[0] = 0; err_cnt[1] = 0;
    repeat (3) cyc();
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", 32'(busy[d]), 0);
      chk("rst_done", 32'(done[d]), 0);
      chk("rst_err", 32'(err[d]), 0);
      chk("rst_rd_valid", 32'(rd_valid[d]), 0);
      chk("rst_rd_data", 32'(rd_data[d]), 0);
    end
    rstn = 1'b1;
    cyc();

    // Alternating bright/dark frame -> 0xAA (0x55 inverted).
    arm(8'h80); vs_pulse(); pix_q.delete();
    for (int i = 0; i < NP; i++) stim_q.push_back((i % 2 == 0) ? 8'hFF : 8'h00);
    stream(0);
    check_done("alt");
    i_rd_en = 1'b1; i_rd_addr = 3'd1; cyc(); i_rd_en = 1'b0;
    chk("alt_byte1", 32'(rd_data[0]), 32'hAA);
    chk("alt_byte1_inv", 32'(rd_data[1]), 32'h55);
    chk("alt_valid1", 32'(rd_valid[0]), 1);
    cyc();
    chk("alt_valid_gone", 32'(rd_valid[0]), 0);
    read_all();

    // Threshold boundary, ignored capture mid-frame, reads during capture.
    arm(8'h80); vs_pulse(); pix_q.delete();
    noise = 1'b1;
    stim_q = '{8'h80, 8'h7F, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h81, 8'h80};
    rand_stim(NP - 8);
    cap_at = 20;
    stream(2);
    cap_at = -1; noise = 1'b0;
    check_done("thr");
    chk("thr_byte0_model", 32'(exp_byte(0, 1'b0)), 32'hA7);
    read_all();
    chk("no_err0", 32'(err_cnt[0]), 0);

    // Truncated frame: 10 pixels, then vsync together with a pixel.
    arm(8'($urandom)); vs_pulse(); pix_q.delete();
    rand_stim(10); stream(1);
    i_vsync = 1'b1; i_de = 1'b1; i_data = 8'($urandom); cyc();
    i_vsync = 1'b0; i_de = 1'b0;
    pix_q.delete();
    rand_stim(NP); stream(2);
    check_done("trunc");
    chk("trunc_err0", 32'(err_cnt[0]), 1);
    chk("trunc_err1", 32'(err_cnt[1]), 1);
    // Pixels and sync after completion must not touch the frame.
    i_de = 1'b1;
    for (int i = 0; i < 20; i++) begin
      i_data = 8'($urandom); i_vsync = (i == 5); cyc();
    end
    i_de = 1'b0; i_vsync = 1'b0; cyc();
    check_done("extra");
    read_all();

    // Reset in the middle of a capture.
    arm(8'($urandom)); vs_pulse(); pix_q.delete();
    rand_stim(20); stream(1);
    rstn = 1'b0; #1;
    for (int d = 0; d < 2; d++) begin
      chk("mrst_busy", 32'(busy[d]), 0);
      chk("mrst_done", 32'(done[d]), 0);
      chk("mrst_err", 32'(err[d]), 0);
      chk("mrst_rd_valid", 32'(rd_valid[d]), 0);
      chk("mrst_rd_data", 32'(rd_data[d]), 0);
    end
    cyc(); rstn = 1'b1; cyc();
    chk("mrst_idle_done", 32'(done[0]), 0);
    arm(8'($urandom)); vs_pulse(); pix_q.delete();
    rand_stim(NP); stream(2);
    check_done("post_rst");
    read_all();

    // Randomised frames.
    err_cnt[0] = 0; err_cnt[1] = 0;
    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(3, 0)) cyc();
      arm(8'($urandom)); repeat ($urandom_range(3, 0)) cyc();
      vs_pulse(); pix_q.delete();
      rand_stim(NP); stream(3);
      check_done("rand");
      read_all();
    end
    chk("rand_no_err", 32'(err_cnt[0] + err_cnt[1]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
